mmcm_drp_arbiter: RTL and testbench

- Shares the single DRP port of one MMCME2_ADV/PLLE2_ADV between two requesters.
- Typical requesters: the reconfiguration sequencer and a debug/readback agent.
- Runs one DRP transaction at a time. Arbitration is round-robin. Drives DEN as a single-cycle pulse, waits for DRDY, then returns read data and a done pulse to the owning requester.
- Sits between the requesters and the MMCM/PLL DRP pins, entirely in the dclk domain.

---
 rtl/mmcm_drp_arbiter_if.sv | 30 +++
 rtl/mmcm_drp_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mmcm_drp_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_arbiter_if.sv
// -----------------------------------------------------------------------------
// mmcm_drp_arbiter_if
//   DRP pin bundle of one MMCME2_ADV / PLLE2_ADV.
//
//   Signals:
//     den    1       enable strobe, one cycle per transaction
//     dwe    1       write enable, qualified by den
//     daddr  ADDR_W  register address
//     di     DATA_W  write data
//     dout   DATA_W  read data returned by the primitive (DO)
//     drdy   1       transaction-complete strobe from the primitive
//
//   Modports:
//     master  the side that issues transactions (the arbiter)
//     slave   the MMCM/PLL side (or a model of it)
// -----------------------------------------------------------------------------
interface mmcm_drp_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              den;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
  logic              drdy;

  modport master (output den, dwe, daddr, di, input dout, drdy);
  modport slave  (input den, dwe, daddr, di, output dout, drdy);
endinterface

// File: rtl/mmcm_drp_arbiter.sv
// -----------------------------------------------------------------------------
// mmcm_drp_arbiter
//   Shares the single DRP port of an MMCM/PLL between two requesters
//   (typically the reconfiguration sequencer and a debug/readback agent).
//   One transaction at a time, round-robin arbitration, single-cycle DEN,
//   then wait for DRDY and return data plus a done pulse to the owner.
//   Everything runs on the rising edge of dclk.
//
//   Ports:
//     dclk, rst_n            DRP clock, asynchronous active-low reset
//     rN_valid               request, held by the requester until rN_done
//     rN_we/addr/wdata       transaction description, sampled only in IDLE
//     rN_done                one-cycle completion pulse
//     rN_rdata               read data, valid with rN_done, held until next
//     rN_err                 timeout flag, valid with rN_done
//     drp                    DRP pins to the primitive (master modport)
//     busy                   high from grant until the done cycle
//     grant                  index of current or last owner
//     spurious_drdy          sticky, drdy seen while not waiting for it
//
//   Build option:
//     DRP_ARB_TIMEOUT_EN     when defined, a transaction with no drdy within
//                            TIMEOUT_CYCLES of the DEN pulse completes with
//                            rN_err=1 and rN_rdata all-ones. When undefined
//                            the wait is unbounded and rN_err is tied low.
// -----------------------------------------------------------------------------
module mmcm_drp_arbiter #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  dclk,
  input  logic                  rst_n,

  input  logic                  r0_valid,
  input  logic                  r0_we,
  input  logic [ADDR_W-1:0]     r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  output logic                  r0_done,
  output logic [DATA_W-1:0]     r0_rdata,
  output logic                  r0_err,

  input  logic                  r1_valid,
  input  logic                  r1_we,
  input  logic [ADDR_W-1:0]     r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  output logic                  r1_done,
  output logic [DATA_W-1:0]     r1_rdata,
  output logic                  r1_err,

  mmcm_drp_arbiter_if.master    drp,

  output logic                  busy,
  output logic                  grant,
  output logic                  spurious_drdy
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mmcm_drp_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic       prio;         // requester that wins when both are valid
  logic       op_we;        // latched direction of the transaction in flight
  logic       pick;
  logic       wait_exit;
  logic       timeout_hit;

  // A lone requester wins; on contention the one not served last wins.
  assign pick      = r1_valid & (~r0_valid | prio);
  assign wait_exit = (state == S_WAIT) && (drp.drdy || timeout_hit);

`ifdef DRP_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Counts WAIT cycles; it is zero in the first WAIT cycle because ISSUE
  // clears it, so the abort lands TIMEOUT_CYCLES cycles after WAIT entry.
  logic [15:0] wait_cnt;

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state != S_WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 16'd1;
  end

  assign timeout_hit = (state == S_WAIT) && !drp.drdy && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r0_err <= 1'b0;
      r1_err <= 1'b0;
    end else if (wait_exit) begin
      if (grant) r1_err <= timeout_hit;
      else       r0_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign r0_err      = 1'b0;
  assign r1_err      = 1'b0;
`endif

  // NOTE: every register in this block uses non-blocking assignments so all
  // of them sample pre-edge values; blocking here would create order races.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      prio          <= 1'b0;
      op_we         <= 1'b0;
      grant         <= 1'b0;
      busy          <= 1'b0;
      spurious_drdy <= 1'b0;
      drp.den       <= 1'b0;
      drp.dwe       <= 1'b0;
      drp.daddr     <= '0;
      drp.di        <= '0;
      r0_done       <= 1'b0;
      r1_done       <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
    end else begin
      // NOTE: strobes default low each cycle so each one is raised by exactly
      // one state transition and can never stick high.
      drp.den <= 1'b0;
      drp.dwe <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;

      if (drp.drdy && state != S_WAIT) spurious_drdy <= 1'b1;

      case (state)
        S_IDLE: begin
          if (r0_valid || r1_valid) begin
            grant     <= pick;
            busy      <= 1'b1;
            op_we     <= pick ? r1_we : r0_we;
            drp.den   <= 1'b1;
            drp.dwe   <= pick ? r1_we : r0_we;
            drp.daddr <= pick ? r1_addr : r0_addr;
            drp.di    <= pick ? r1_wdata : r0_wdata;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (wait_exit) begin
            busy  <= 1'b0;
            state <= S_DONE;
            if (grant) r1_done <= 1'b1;
            else       r0_done <= 1'b1;
            // Writes leave rdata alone; an aborted transaction reads all-ones.
            if (timeout_hit) begin
              if (grant) r1_rdata <= '1;
              else       r0_rdata <= '1;
            end else if (!op_we) begin
              if (grant) r1_rdata <= drp.dout;
              else       r0_rdata <= drp.dout;
            end
          end
        end
        S_DONE: begin
          prio  <= ~grant;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmcm_drp_arbiter
//   Self-checking bench for mmcm_drp_arbiter. A behavioural DRP slave answers
//   each DEN after a programmable delay. Every expected transaction is pushed
//   to two queues when the stimulus is set up: one is popped on DEN (address,
//   direction, data, owner), the other on rN_done (owner, rdata, err, latency).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mmcm_drp_arbiter;

`ifdef DRP_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef struct {
    int          who;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        dclk;
  logic        rst_n;
  logic [1:0]  r_valid;
  logic [1:0]  r_we;
  logic [6:0]  r_addr  [2];
  logic [15:0] r_wdata [2];
  logic [1:0]  r_done;
  logic [15:0] r_rdata [2];
  logic [1:0]  r_err;
  logic        busy;
  logic        grant;
  logic        spurious_drdy;

  mmcm_drp_arbiter_if #(.ADDR_W(7), .DATA_W(16)) drp_bus ();

  mmcm_drp_arbiter #(
    .ADDR_W(7), .DATA_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .dclk(dclk), .rst_n(rst_n),
    .r0_valid(r_valid[0]), .r0_we(r_we[0]), .r0_addr(r_addr[0]), .r0_wdata(r_wdata[0]),
    .r0_done(r_done[0]), .r0_rdata(r_rdata[0]), .r0_err(r_err[0]),
    .r1_valid(r_valid[1]), .r1_we(r_we[1]), .r1_addr(r_addr[1]), .r1_wdata(r_wdata[1]),
    .r1_done(r_done[1]), .r1_rdata(r_rdata[1]), .r1_err(r_err[1]),
    .drp(drp_bus),
    .busy(busy), .grant(grant), .spurious_drdy(spurious_drdy)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   den_cyc = 0;
  int   drdy_delay = 1;
  int   drdy_hold  = 1;
  bit   drdy_never = 1'b0;
  int   spur_cnt   = 0;
  exp_t sb_q[$];
  exp_t den_q[$];
  logic [15:0] mem [128];

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {drp_bus.den, drp_bus.dwe, drp_bus.daddr, drp_bus.di, r_done,
            r_rdata[0], r_rdata[1], r_err, busy, grant, spurious_drdy};
  endfunction

  task automatic expect_txn(input int who, input logic we, input logic [6:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input logic err, input int lat);
    exp_t e;
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.lat = lat;
    sb_q.push_back(e);
    den_q.push_back(e);
  endtask

  task automatic setup(input int who, input logic we, input logic [6:0] addr,
                       input logic [15:0] wdata);
    r_we[who]    = we;
    r_addr[who]  = addr;
    r_wdata[who] = wdata;
  endtask

  // Holds each requester valid until it has seen its quota of done pulses,
  // dropping valid in the done cycle as a real requester would.
  task automatic run_pair(input int n0, input int n1);
    int cnt0, cnt1, budget;
    cnt0 = 0; cnt1 = 0; budget = 0;
    r_valid = {n1 > 0, n0 > 0};
    while ((cnt0 < n0 || cnt1 < n1) && budget < 400) begin
      @(negedge dclk);
      budget++;
      if (r_done[0]) begin cnt0++; if (cnt0 >= n0) r_valid[0] = 1'b0; end
      if (r_done[1]) begin cnt1++; if (cnt1 >= n1) r_valid[1] = 1'b0; end
    end
    r_valid = 2'b00;
    check("done_count_r0", 64'(cnt0), 64'(n0));
    check("done_count_r1", 64'(cnt1), 64'(n1));
  endtask

  // Behavioural MMCM DRP slave plus DEN-side scoreboard.
  initial begin : drp_model
    int          cd;
    int          hold_left;
    int          spur_seen;
    logic [15:0] lat_dout;
    exp_t        e;
    cd = 0; hold_left = 0; spur_seen = 0; lat_dout = '0;
    foreach (mem[i]) mem[i] = '0;
    mem[8] = 16'h1041;
    drp_bus.drdy = 1'b0;
    drp_bus.dout = '0;
    forever begin
      @(negedge dclk);
      if (!rst_n) begin
        cd = 0; hold_left = 0; drp_bus.drdy = 1'b0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) drp_bus.drdy = 1'b0;
        end
        if (spur_seen != spur_cnt) begin
          spur_seen = spur_cnt; drp_bus.drdy = 1'b1; hold_left = 1;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            drp_bus.drdy = 1'b1; drp_bus.dout = lat_dout; hold_left = drdy_hold;
          end
        end
        if (drp_bus.den) begin
          den_cyc = cyc;
          check("den_expected", 64'(den_q.size() != 0), 64'd1);
          if (den_q.size() != 0) begin
            e = den_q.pop_front();
            check("den_grant", 64'(grant), 64'(e.who));
            check("den_busy", 64'(busy), 64'd1);
            check("den_dwe", 64'(drp_bus.dwe), 64'(e.we));
            check("den_daddr", 64'(drp_bus.daddr), 64'(e.addr));
            if (e.we) check("den_di", 64'(drp_bus.di), 64'(e.wdata));
          end
          if (drp_bus.dwe) begin
            mem[drp_bus.daddr] = drp_bus.di;
            lat_dout = 16'hDEAD;
          end else begin
            lat_dout = mem[drp_bus.daddr];
          end
          if (!drdy_never) cd = drdy_delay;
        end
      end
    end
  end

  // Done-side scoreboard.
  initial begin : done_monitor
    exp_t e;
    forever begin
      @(negedge dclk);
      for (int i = 0; i < 2; i++) begin
        if (r_done[i]) begin
          check("done_other_low", 64'(r_done[1-i]), 64'd0);
          check("done_expected", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("done_owner", 64'(i), 64'(e.who));
            check("done_grant", 64'(grant), 64'(e.who));
            check("done_rdata", 64'(r_rdata[i]), 64'(e.rdata));
            check("done_err", 64'(r_err[i]), 64'(e.err));
            check("done_busy_low", 64'(busy), 64'd0);
            check("done_latency", 64'(cyc - den_cyc), 64'(e.lat));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    r_valid = 2'b00;
    r_we = 2'b00;
    for (int i = 0; i < 2; i++) begin r_addr[i] = '0; r_wdata[i] = '0; end
    repeat (3) @(negedge dclk);
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge dclk);

    // Single read: drdy 3 cycles after den, done 4 cycles after den.
    drdy_delay = 3;
    setup(0, 1'b0, 7'h08, 16'h0000);
    expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'h1041, 1'b0, 4);
    run_pair(1, 0);
    repeat (3) @(negedge dclk);
    check("r0_rdata_held", 64'(r_rdata[0]), 64'h1041);
    check("r1_rdata_untouched", 64'(r_rdata[1]), 64'h0000);

    // Single write, then a readback by the same requester.
    drdy_delay = 2;
    setup(1, 1'b1, 7'h14, 16'h0145);
    expect_txn(1, 1'b1, 7'h14, 16'h0145, 16'h0000, 1'b0, 3);
    run_pair(0, 1);
    @(negedge dclk);
    drdy_delay = 1;
    setup(1, 1'b0, 7'h14, 16'h0000);
    expect_txn(1, 1'b0, 7'h14, 16'h0000, 16'h0145, 1'b0, 2);
    run_pair(0, 1);
    @(negedge dclk);

    // Continuous contention: strict alternation 0,1,0,1,0,1.
    setup(0, 1'b0, 7'h08, 16'h0000);
    setup(1, 1'b1, 7'h20, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'h1041, 1'b0, 2);
      expect_txn(1, 1'b1, 7'h20, 16'hBEEF, 16'h0145, 1'b0, 2);
    end
    run_pair(3, 3);
    repeat (2) @(negedge dclk);

    // Spurious drdy in IDLE, then a drdy held for 3 cycles in WAIT.
    check("spurious_clear", 64'(spurious_drdy), 64'd0);
    spur_cnt++;
    repeat (3) @(negedge dclk);
    check("spurious_set_idle", 64'(spurious_drdy), 64'd1);
    drdy_hold = 3;
    setup(1, 1'b0, 7'h20, 16'h0000);
    expect_txn(1, 1'b0, 7'h20, 16'h0000, 16'hBEEF, 1'b0, 2);
    run_pair(0, 1);
    repeat (6) @(negedge dclk);
    check("held_drdy_single_done", 64'(sb_q.size()), 64'd0);
    check("spurious_sticky", 64'(spurious_drdy), 64'd1);
    drdy_hold = 1;

    // Reset mid-transaction; the pointer must return to favour requester 0.
    setup(0, 1'b0, 7'h08, 16'h0000);
    expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'h1041, 1'b0, 2);
    run_pair(1, 0);
    @(negedge dclk);
    drdy_never = 1'b1;
    setup(1, 1'b0, 7'h14, 16'h0000);
    expect_txn(1, 1'b0, 7'h14, 16'h0000, 16'h0145, 1'b0, 2);
    r_valid[1] = 1'b1;
    repeat (5) @(negedge dclk);
    check("busy_in_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", out_vec(), 64'd0);
    sb_q.delete();
    den_q.delete();
    drdy_never = 1'b0;
    setup(0, 1'b0, 7'h08, 16'h0000);
    expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'h1041, 1'b0, 2);
    expect_txn(1, 1'b0, 7'h14, 16'h0000, 16'h0145, 1'b0, 2);
    r_valid = 2'b11;
    @(negedge dclk);
    rst_n = 1'b1;
    run_pair(1, 1);
    @(negedge dclk);

`ifdef DRP_ARB_TIMEOUT_EN
    // No drdy at all: abort TO cycles after WAIT entry, then a normal read.
    drdy_never = 1'b1;
    setup(0, 1'b0, 7'h08, 16'h0000);
    expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'hFFFF, 1'b1, TO + 1);
    run_pair(1, 0);
    @(negedge dclk);
    drdy_never = 1'b0;
    drdy_delay = 2;
    expect_txn(0, 1'b0, 7'h08, 16'h0000, 16'h1041, 1'b0, 3);
    run_pair(1, 0);
`endif

    repeat (5) @(negedge dclk);
    check("scoreboard_drained", 64'(sb_q.size() + den_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
